// File: rtl/prio_arbiter4_if.sv
// Request/grant bundle for the 4-way priority arbiter.
// The arbiter sits on the slave side; requesters sit on the master side.
interface prio_arbiter4_if;
  logic [3:0] req;
  logic       mode;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output mode,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  mode,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/prio_arbiter4.sv
// Four-requester arbiter with fixed-priority or round-robin selection,
// a bounded hold time per grant and a one-cycle gap between grants.
module prio_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  prio_arbiter4_if.slave  arb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] fixed_id;
  logic [1:0] rr_id;
  logic [1:0] rr_idx;
  logic       rr_found;
  logic [1:0] win_id;

  // Winner selection; only consumed in IDLE, so req/mode never reach an output directly.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    fixed_id = 2'd0;
    rr_id    = 2'd0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    // Ascending scan: the last set bit seen, i.e. the highest, wins.
    for (int i = 0; i < 4; i++) begin
      if (arb.req[i]) fixed_id = 2'(i);
    end
    // Round-robin scan starts at ptr and wraps naturally in 2 bits.
    for (int k = 0; k < 4; k++) begin
      rr_idx = ptr_q + 2'(k);
      if (!rr_found && arb.req[rr_idx]) begin
        rr_id    = rr_idx;
        rr_found = 1'b1;
      end
    end
    win_id = arb.mode ? rr_id : fixed_id;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (|arb.req) begin
          state_d  = GRANT;
          gnt_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          busy_d   = 1'b1;
          cnt_d    = 8'd1;
          if (arb.mode) ptr_d = win_id + 2'd1;
        end
      end
      GRANT: begin
        if (!arb.req[gnt_id_q] || cnt_q == HOLD_MAX_C) begin
          state_d   = GAP;
          gnt_d     = 4'b0000;
          gnt_id_d  = 2'd0;
          cnt_d     = 8'd0;
          // Only a still-requesting owner is being cut off by the hold limit.
          timeout_d = arb.req[gnt_id_q];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
        busy_d   = 1'b0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arb.gnt     = gnt_q;
  assign arb.gnt_id  = gnt_id_q;
  assign arb.busy    = busy_q;
  assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_prio_arbiter4.sv
// Directed bench for prio_arbiter4 with HOLD_MAX = 8, 2 and 1 instances
// sharing one clock and reset.
module tb_prio_arbiter4;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  prio_arbiter4_if bus8 ();
  prio_arbiter4_if bus2 ();
  prio_arbiter4_if bus1 ();

  prio_arbiter4 #(.HOLD_MAX(8)) dut8 (.clk(clk), .rst(rst), .arb(bus8.slave));
  prio_arbiter4 #(.HOLD_MAX(2)) dut2 (.clk(clk), .rst(rst), .arb(bus2.slave));
  prio_arbiter4 #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst), .arb(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus8.req = 4'b0000;
    bus2.req = 4'b0000;
    bus1.req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.req = 4'b1111; bus8.mode = 1'b0;
    bus2.req = 4'b1111; bus2.mode = 1'b1;
    bus1.req = 4'b1111; bus1.mode = 1'b0;
    tick();
    tick();
    n_total++; if (bus8.gnt !== 4'b0000) $display("FAIL reset_gnt8: got %b want 0000", bus8.gnt); else n_pass++;
    n_total++; if (bus8.gnt_id !== 2'd0) $display("FAIL reset_id8: got %0d want 0", bus8.gnt_id); else n_pass++;
    n_total++; if (bus8.busy !== 1'b0) $display("FAIL reset_busy8: got %b want 0", bus8.busy); else n_pass++;
    n_total++; if (bus8.timeout !== 1'b0) $display("FAIL reset_to8: got %b want 0", bus8.timeout); else n_pass++;
    n_total++; if (bus2.gnt !== 4'b0000) $display("FAIL reset_gnt2: got %b want 0000", bus2.gnt); else n_pass++;
    n_total++; if (bus1.busy !== 1'b0) $display("FAIL reset_busy1: got %b want 0", bus1.busy); else n_pass++;
    bus8.req = 4'b0000;
    bus2.req = 4'b0000;
    bus1.req = 4'b0000;
    rst = 1'b0;
    tick();
    n_total++; if (bus8.busy !== 1'b0) $display("FAIL idle_busy8: got %b want 0", bus8.busy); else n_pass++;
  endtask

  task automatic test_fixed_priority();
    bus8.mode = 1'b0;
    bus8.req  = 4'b0110;
    tick();
    n_total++; if (bus8.gnt !== 4'b0100) $display("FAIL fixed_gnt: got %b want 0100", bus8.gnt); else n_pass++;
    n_total++; if (bus8.gnt_id !== 2'd2) $display("FAIL fixed_id: got %0d want 2", bus8.gnt_id); else n_pass++;
    n_total++; if (bus8.busy !== 1'b1) $display("FAIL fixed_busy: got %b want 1", bus8.busy); else n_pass++;
    bus8.req = 4'b0010;
    tick();
    n_total++; if (bus8.gnt !== 4'b0000) $display("FAIL fixed_gap_gnt: got %b want 0000", bus8.gnt); else n_pass++;
    n_total++; if (bus8.timeout !== 1'b0) $display("FAIL fixed_gap_to: got %b want 0", bus8.timeout); else n_pass++;
    n_total++; if (bus8.busy !== 1'b1) $display("FAIL fixed_gap_busy: got %b want 1", bus8.busy); else n_pass++;
    tick();
    n_total++; if (bus8.gnt !== 4'b0000) $display("FAIL fixed_idle_gnt: got %b want 0000", bus8.gnt); else n_pass++;
    n_total++; if (bus8.busy !== 1'b0) $display("FAIL fixed_idle_busy: got %b want 0", bus8.busy); else n_pass++;
    tick();
    n_total++; if (bus8.gnt !== 4'b0010) $display("FAIL fixed_regrant_gnt: got %b want 0010", bus8.gnt); else n_pass++;
    n_total++; if (bus8.gnt_id !== 2'd1) $display("FAIL fixed_regrant_id: got %0d want 1", bus8.gnt_id); else n_pass++;
    drain();
  endtask

  task automatic test_timeout();
    bus8.mode = 1'b0;
    bus8.req  = 4'b1111;
    tick();
    n_total++; if (bus8.gnt !== 4'b1000) $display("FAIL to_hold_c1: got %b want 1000", bus8.gnt); else n_pass++;
    for (int i = 2; i <= 8; i++) begin
      tick();
      n_total++; if (bus8.gnt !== 4'b1000 || bus8.timeout !== 1'b0)
        $display("FAIL to_hold_c%0d: got gnt %b to %b want 1000/0", i, bus8.gnt, bus8.timeout); else n_pass++;
    end
    tick();
    n_total++; if (bus8.gnt !== 4'b0000) $display("FAIL to_gap_gnt: got %b want 0000", bus8.gnt); else n_pass++;
    n_total++; if (bus8.timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", bus8.timeout); else n_pass++;
    n_total++; if (bus8.gnt_id !== 2'd0) $display("FAIL to_gap_id: got %0d want 0", bus8.gnt_id); else n_pass++;
    tick();
    n_total++; if (bus8.timeout !== 1'b0) $display("FAIL to_pulse_end: got %b want 0", bus8.timeout); else n_pass++;
    n_total++; if (bus8.gnt !== 4'b0000 || bus8.busy !== 1'b0)
      $display("FAIL to_idle: got gnt %b busy %b want 0000/0", bus8.gnt, bus8.busy); else n_pass++;
    tick();
    n_total++; if (bus8.gnt !== 4'b1000) $display("FAIL to_regrant: got %b want 1000", bus8.gnt); else n_pass++;
    n_total++; if (bus8.gnt_id !== 2'd3) $display("FAIL to_regrant_id: got %0d want 3", bus8.gnt_id); else n_pass++;
    drain();
  endtask

  task automatic test_single_cycle();
    bus8.mode = 1'b0;
    bus8.req  = 4'b0001;
    tick();
    n_total++; if (bus8.gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", bus8.gnt); else n_pass++;
    bus8.req = 4'b0000;
    tick();
    n_total++; if (bus8.gnt !== 4'b0000 || bus8.busy !== 1'b1)
      $display("FAIL single_gap: got gnt %b busy %b want 0000/1", bus8.gnt, bus8.busy); else n_pass++;
    n_total++; if (bus8.timeout !== 1'b0) $display("FAIL single_gap_to: got %b want 0", bus8.timeout); else n_pass++;
    tick();
    n_total++; if (bus8.busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", bus8.busy); else n_pass++;
    drain();
  endtask

  task automatic test_preempt_mode();
    // ptr of dut8 has only seen fixed-mode grants, so it is still 0.
    bus8.mode = 1'b0;
    bus8.req  = 4'b0001;
    tick();
    n_total++; if (bus8.gnt !== 4'b0001) $display("FAIL pre_gnt_c1: got %b want 0001", bus8.gnt); else n_pass++;
    bus8.mode = 1'b1;
    bus8.req  = 4'b1001;
    for (int i = 2; i <= 8; i++) begin
      tick();
      n_total++; if (bus8.gnt !== 4'b0001) $display("FAIL pre_gnt_c%0d: got %b want 0001", i, bus8.gnt); else n_pass++;
    end
    tick();
    n_total++; if (bus8.gnt !== 4'b0000 || bus8.timeout !== 1'b1)
      $display("FAIL pre_timeout: got gnt %b to %b want 0000/1", bus8.gnt, bus8.timeout); else n_pass++;
    tick();
    tick();
    n_total++; if (bus8.gnt !== 4'b0001) $display("FAIL pre_rr_regrant: got %b want 0001", bus8.gnt); else n_pass++;
    n_total++; if (bus8.gnt_id !== 2'd0) $display("FAIL pre_rr_id: got %0d want 0", bus8.gnt_id); else n_pass++;
    drain();
  endtask

  task automatic test_hold_one();
    bus1.mode = 1'b0;
    bus1.req  = 4'b0011;
    tick();
    n_total++; if (bus1.gnt !== 4'b0010) $display("FAIL h1_gnt: got %b want 0010", bus1.gnt); else n_pass++;
    tick();
    n_total++; if (bus1.gnt !== 4'b0000 || bus1.timeout !== 1'b1)
      $display("FAIL h1_revoke: got gnt %b to %b want 0000/1", bus1.gnt, bus1.timeout); else n_pass++;
    tick();
    n_total++; if (bus1.busy !== 1'b0) $display("FAIL h1_idle: got %b want 0", bus1.busy); else n_pass++;
    tick();
    n_total++; if (bus1.gnt !== 4'b0010) $display("FAIL h1_regrant: got %b want 0010", bus1.gnt); else n_pass++;
    drain();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus2.mode = 1'b1;
    bus2.req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      n_total++; if (bus2.gnt !== exp_gnt) $display("FAIL rr_g%0d_c1: got %b want %b", k, bus2.gnt, exp_gnt); else n_pass++;
      tick();
      n_total++; if (bus2.gnt !== exp_gnt) $display("FAIL rr_g%0d_c2: got %b want %b", k, bus2.gnt, exp_gnt); else n_pass++;
      tick();
      n_total++; if (bus2.gnt !== 4'b0000 || bus2.timeout !== 1'b1)
        $display("FAIL rr_g%0d_to: got gnt %b to %b want 0000/1", k, bus2.gnt, bus2.timeout); else n_pass++;
      tick();
      n_total++; if (bus2.busy !== 1'b0 || bus2.timeout !== 1'b0)
        $display("FAIL rr_g%0d_idle: got busy %b to %b want 0/0", k, bus2.busy, bus2.timeout); else n_pass++;
    end
    drain();
  endtask

  task automatic test_reset_mid_grant();
    bus2.mode = 1'b1;
    bus2.req  = 4'b0100;
    tick();
    n_total++; if (bus2.gnt !== 4'b0100) $display("FAIL rmg_setup: got %b want 0100", bus2.gnt); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (bus2.gnt !== 4'b0000 || bus2.busy !== 1'b0 || bus2.timeout !== 1'b0)
      $display("FAIL rmg_after: got gnt %b busy %b to %b want 0000/0/0", bus2.gnt, bus2.busy, bus2.timeout); else n_pass++;
    rst = 1'b0;
    bus2.req = 4'b1001;
    tick();
    n_total++; if (bus2.gnt !== 4'b0001) $display("FAIL rmg_ptr0: got %b want 0001", bus2.gnt); else n_pass++;
    tick();
    n_total++; if (bus2.gnt !== 4'b0001) $display("FAIL rmg_hold: got %b want 0001", bus2.gnt); else n_pass++;
    // Reset lands on the edge that would otherwise revoke with a timeout.
    rst = 1'b1;
    tick();
    n_total++; if (bus2.gnt !== 4'b0000 || bus2.timeout !== 1'b0 || bus2.busy !== 1'b0)
      $display("FAIL rmg_no_pulse: got gnt %b to %b busy %b want 0000/0/0", bus2.gnt, bus2.timeout, bus2.busy); else n_pass++;
    rst = 1'b0;
    drain();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus8.req = 4'b0000; bus8.mode = 1'b0;
    bus2.req = 4'b0000; bus2.mode = 1'b0;
    bus1.req = 4'b0000; bus1.mode = 1'b0;
    test_reset();
    test_fixed_priority();
    test_timeout();
    test_single_cycle();
    test_preempt_mode();
    test_hold_one();
    test_round_robin();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prio_arbiter4.md
PRIO_ARBITER4 -- requirements
Module: prio_arbiter4

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, giving the maximum consecutive cycles one grant is held (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port req  input  4  request lines; req[3] is the highest fixed priority and req[0] the lowest.
REQ-005 SHALL have port mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-006 SHALL have port gnt  output  4  one-hot grant, or all zero when no grant is active.
REQ-007 SHALL have port gnt_id  output  2  binary index of the granted requester, 0 when gnt is 0.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse indicating a grant was revoked at HOLD_MAX.

Function
REQ-010 SHALL implement the FSM states IDLE, GRANT and GAP, encoded in registers.
REQ-011 SHALL register every output; no combinational path from req or mode to any output.
REQ-012 In IDLE with req != 0 at edge N, SHALL assert gnt and gnt_id for the winner from cycle N+1 and enter GRANT; with req == 0, SHALL stay in IDLE.
REQ-013 Fixed-priority mode SHALL select the highest set bit of req, with req[3] winning over all others.
REQ-014 Round-robin mode SHALL search ptr, ptr+1, ... modulo 4 (wrapping 3->0), select the first set bit, and on each grant load ptr = winner+1 mod 4.
REQ-015 SHALL keep ptr unchanged on grants made in fixed-priority mode.
REQ-016 SHALL sample mode only at the arbitration edge; a mode change while busy has no effect on the current grant.
REQ-017 SHALL keep hold counter cnt (8 bits) at 1 in the first GRANT cycle and increment it each further GRANT cycle.
REQ-018 In GRANT, if req[gnt_id] = 0 at an edge, SHALL clear gnt and gnt_id and enter GAP with timeout = 0.
REQ-019 In GRANT, if req[gnt_id] = 1 and cnt == HOLD_MAX at an edge, SHALL clear gnt, enter GAP and assert timeout for that single GAP cycle.
REQ-020 SHALL therefore hold gnt high for at most HOLD_MAX consecutive cycles.
REQ-021 SHALL keep the current grant regardless of other requests, including higher-priority ones, arriving during GRANT (no preemption).
REQ-022 SHALL hold GAP for exactly one cycle with gnt = 0, then enter IDLE.
REQ-023 Minimum re-grant spacing SHALL be: gnt low at N+1 (GAP), IDLE at N+2, new gnt at N+3, where N is the revoke edge.
REQ-024 With HOLD_MAX = 1, SHALL hold each grant for exactly one cycle.
REQ-025 A requester revoked by timeout SHALL be eligible again at the next arbitration (fixed mode may re-grant it).

Reset
REQ-026 When rst = 1 at an edge, SHALL set state = IDLE, gnt = 0, gnt_id = 0, busy = 0, timeout = 0, ptr = 0 and cnt = 0, overriding all other conditions.
REQ-027 On reset asserted mid-GRANT or mid-GAP, SHALL have gnt = 0 in the cycle after the reset edge with no timeout pulse.
REQ-028 SHALL perform no arbitration in any cycle where rst = 1; arbitration resumes from the first edge with rst = 0.

Verification
REQ-029 Fixed priority (mode = 0, HOLD_MAX = 8): req = 4'b0110 -> gnt = 0100 and gnt_id = 2 next cycle; drop req[2] -> one GAP cycle, IDLE, then gnt = 0010 and gnt_id = 1.
REQ-030 Timeout: req = 4'b1111 held, mode = 0 -> gnt = 1000 for exactly 8 cycles, timeout = 1 for one cycle with gnt = 0, then gnt = 1000 again.
REQ-031 Round-robin after reset: req = 4'b1111 held, mode = 1, HOLD_MAX = 2 -> grant order 0001, 0010, 0100, 1000, 0001, each held 2 cycles with a timeout pulse after each.
REQ-032 Single-cycle request: req = 4'b0001 for one cycle only -> gnt = 0001 for exactly one cycle, then GAP, then IDLE with busy = 0.
REQ-033 Reset mid-grant: gnt = 0100 active, rst = 1 for one edge -> next cycle gnt = 0, busy = 0, timeout = 0; in round-robin the next grant search starts at ptr = 0.
REQ-034 Mode and preemption: toggle mode and raise req[3] during a req[0] grant -> gnt stays 0001 until req[0] drops or HOLD_MAX is reached.
